// File: rtl/eth_pkg.sv
// eth_pkg: shared types and helpers for the switch datapath blocks
package eth_pkg;
  typedef enum logic {NORMAL, DROP} pf_state_e;
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/sdp_ram.sv
// sdp_ram: simple dual-port storage, one write port and one registered read port
module sdp_ram #(
  parameter int W  = 9,
  parameter int D  = 64,
  parameter int AW = $clog2(D)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [D];
  // array write; the storage itself carries no reset
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // read register clears on reset and holds between reads
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/pkt_fifo.sv
// pkt_fifo: frame-aware FIFO that exposes only fully committed frames to the reader
module pkt_fifo import eth_pkg::*; #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 64,
  parameter int AFULL_MARGIN = 8,
  parameter int CNT_W        = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       wr_last,
  input  logic                       wr_abort,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_last,
  output logic                       rd_valid,
  output logic                       empty,
  output logic                       full,
  output logic                       afull,
  output logic [ptr_w(DEPTH)-1:0]    level,
  output logic [ptr_w(DEPTH)-1:0]    pkt_count,
  output logic [CNT_W-1:0]           drop_cnt
);
  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  logic [PW-1:0] wr_ptr, cm_ptr, rd_ptr;
  pf_state_e state;
  logic do_wr, do_rd, commit, rewind, drop_evt;
  assign level    = wr_ptr - rd_ptr;
  assign empty    = rd_ptr == cm_ptr;
  assign full     = level == PW'(DEPTH);
  assign afull    = level >= PW'(DEPTH - AFULL_MARGIN);
  assign do_rd    = rd_en && !empty;
  assign do_wr    = wr_en && !full && state == NORMAL && !(wr_last && wr_abort);
  assign commit   = do_wr && wr_last;
  assign rewind   = state == NORMAL && wr_en && (full || (wr_last && wr_abort));
  assign drop_evt = wr_en && wr_last && (state == DROP || full || wr_abort);
  sdp_ram #(.W(WIDTH + 1), .D(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .rstn  (rstn),
    .we    (do_wr),
    .waddr (wr_ptr[AW-1:0]),
    .wdata ({wr_last, wr_data}),
    .re    (do_rd),
    .raddr (rd_ptr[AW-1:0]),
    .rdata ({rd_last, rd_data})
  );
  // pointers, drop FSM and counters; a frame's last beat leaving the output retires it from pkt_count
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wr_ptr    <= '0;
      cm_ptr    <= '0;
      rd_ptr    <= '0;
      rd_valid  <= 1'b0;
      pkt_count <= '0;
      drop_cnt  <= '0;
      state     <= NORMAL;
    end else begin
      rd_valid  <= do_rd;
      rd_ptr    <= rd_ptr + PW'(do_rd);
      wr_ptr    <= rewind ? cm_ptr : wr_ptr + PW'(do_wr);
      if (commit) cm_ptr <= wr_ptr + PW'(1);
      pkt_count <= pkt_count + PW'(commit) - PW'(rd_valid && rd_last);
      if (drop_evt && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
      state     <= (state == NORMAL && wr_en && full && !wr_last) ? DROP :
                   (state == DROP && wr_en && wr_last) ? NORMAL : state;
    end
endmodule

// File: tb/tb_pkt_fifo.sv
// tb_pkt_fifo: randomized and directed checks of pkt_fifo against a frame-level queue model
module tb_pkt_fifo;
  localparam int W = 8, D = 8, AM = 2, CW = 4, PW = $clog2(D) + 1;
  localparam int SAT = (1 << CW) - 1;
  logic clk = 1'b0, rstn = 1'b0;
  logic wr_en = 1'b0, wr_last = 1'b0, wr_abort = 1'b0, rd_en = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic [W-1:0] rd_data;
  logic rd_last, rd_valid, empty, full, afull;
  logic [PW-1:0] level, pkt_count;
  logic [CW-1:0] drop_cnt;

  pkt_fifo #(.WIDTH(W), .DEPTH(D), .AFULL_MARGIN(AM), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last),
    .wr_abort(wr_abort), .rd_en(rd_en), .rd_data(rd_data), .rd_last(rd_last),
    .rd_valid(rd_valid), .empty(empty), .full(full), .afull(afull), .level(level),
    .pkt_count(pkt_count), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic [W:0] cq[$];
  logic [W:0] pq[$];
  bit in_drop = 0;
  int drops = 0;
  bit ev = 0, el = 0;
  logic [W-1:0] ed = '0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    int lc = 0;
    int st = cq.size() + pq.size();
    foreach (cq[i]) lc += int'(cq[i][W]);
    check("rd_valid", int'(rd_valid), int'(ev));
    check("rd_data", int'(rd_data), int'(ed));
    check("rd_last", int'(rd_last), int'(el));
    check("empty", int'(empty), int'(cq.size() == 0));
    check("full", int'(full), int'(st == D));
    check("afull", int'(afull), int'(st >= D - AM));
    check("level", int'(level), st);
    check("pkt_count", int'(pkt_count), lc + int'(ev && el));
    check("drop_cnt", int'(drop_cnt), drops);
  endtask

  task automatic bump();
    drops = (drops == SAT) ? SAT : drops + 1;
  endtask

  task automatic cyc(input bit we, input logic [W-1:0] wd, input bit wl, input bit wa, input bit re);
    bit f = (cq.size() + pq.size()) == D;
    wr_en = we; wr_data = wd; wr_last = wl; wr_abort = wa; rd_en = re;
    if (re && cq.size() > 0) begin
      {el, ed} = cq.pop_front();
      ev = 1;
    end else ev = 0;
    if (we) begin
      if (in_drop) begin
        if (wl) begin bump(); in_drop = 0; end
      end else if (f) begin
        pq.delete();
        if (wl) bump(); else in_drop = 1;
      end else if (wl && wa) begin
        pq.delete();
        bump();
      end else begin
        pq.push_back({wl, wd});
        if (wl) begin
          foreach (pq[i]) cq.push_back(pq[i]);
          pq.delete();
        end
      end
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    wr_en = 0; rd_en = 0; wr_last = 0; wr_abort = 0;
    #3;
    rstn = 0;
    cq.delete(); pq.delete(); in_drop = 0; drops = 0; ev = 0; el = 0; ed = '0;
    #1;
    compare_all();
    #3;
    rstn = 1;
  endtask

  task automatic idle_read(input int n);
    repeat (n) cyc(0, '0, 0, 0, 1);
  endtask

  initial begin
    #2;
    compare_all();
    #10;
    rstn = 1;
    cyc(1, 8'h11, 0, 0, 0);
    cyc(1, 8'h22, 0, 0, 0);
    cyc(1, 8'h33, 1, 0, 0);
    idle_read(5);
    for (int i = 0; i < 4; i++) cyc(1, W'(8'h40 + i), i == 3, i == 3, 0);
    cyc(0, '0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, W'(8'h50 + i), i == 9, 0, 0);
    cyc(1, 8'h61, 0, 0, 0);
    cyc(1, 8'h62, 1, 0, 0);
    idle_read(4);
    for (int i = 0; i < 5; i++) cyc(1, W'(8'h70 + i), i == 4, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, W'(8'h80 + i), i == 5, 0, 0);
    idle_read(8);
    for (int f = 0; f < 40; f++)
      for (int b = 0; b < 3; b++) cyc(1, W'(f * 3 + b), b == 2, 0, 1);
    idle_read(6);
    cyc(1, 8'hA0, 0, 0, 0);
    cyc(1, 8'hA1, 1, 0, 0);
    cyc(1, 8'hA2, 0, 0, 1);
    do_reset();
    cyc(1, 8'hB0, 0, 0, 0);
    cyc(1, 8'hB1, 1, 0, 0);
    idle_read(4);
    for (int i = 0; i < 20; i++) cyc(1, W'(i), 1, 1, 0);
    do_reset();
    repeat (1500)
      cyc($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 3) == 0,
          $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
    repeat (1500)
      cyc($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 5) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0);
    idle_read(12);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pkt_fifo.md
Name: pkt_fifo

Overview:
Frame-aware synchronous FIFO for the switch ingress/egress path: a parametrised successor to the plain byte FIFO.
- Write side pushes frame beats with an end-of-frame marker. A frame becomes visible to the reader only once its last beat is committed.
- Frames aborted by the MAC (bad FCS) or truncated by overflow are rewound and never reach the reader.
- Provides level, almost-full, committed-frame count and drop counter for the forwarding/scheduler logic.

Parameters:
WIDTH, 8, data beat width in bits
DEPTH, 64, storage entries; power of two, >= 4
AFULL_MARGIN, 8, afull asserted when level >= DEPTH-AFULL_MARGIN; 1..DEPTH-1
CNT_W, 16, width of drop_cnt (saturating)

Ports:
clk  in  1  clock, all logic on rising edge
rstn  in  1  asynchronous active-low reset
wr_en  in  1  write beat request
wr_data  in  WIDTH  write beat data
wr_last  in  1  beat is last of frame
wr_abort  in  1  qualifies wr_last beat: 1 = discard whole frame; ignored when wr_last=0
rd_en  in  1  read beat request
rd_data  out  WIDTH  read data, registered
rd_last  out  1  read beat is last of frame, registered
rd_valid  out  1  rd_data/rd_last valid this cycle
empty  out  1  no committed beats available
full  out  1  storage holds DEPTH beats (committed + speculative)
afull  out  1  almost full
level  out  $clog2(DEPTH)+1  beats stored (wr_ptr - rd_ptr)
pkt_count  out  $clog2(DEPTH)+1  committed frames not yet fully read
drop_cnt  out  CNT_W  frames dropped (abort or overflow), saturates at all-ones

Behaviour:
- Reset (async, rstn=0): all pointers 0, rd_data=0, rd_last=0, rd_valid=0, empty=1, full=0, afull=0, level=0, pkt_count=0, drop_cnt=0, overflow state cleared. A frame partially written at reset is lost.
- Storage is WIDTH+1 bits per entry ({last, data}).
- Pointers are $clog2(DEPTH)+1 bits with a wrap bit:
  - wr_ptr: speculative write position.
  - cm_ptr: commit boundary.
  - rd_ptr: read position.
- empty = (rd_ptr == cm_ptr). full = (wr_ptr - rd_ptr == DEPTH). All flags are decoded from registered state only; no input-to-output combinational path.
- Write, normal state, wr_en=1 and full=0: store the beat at wr_ptr, wr_ptr+1. Then, if wr_last=1:
  - wr_abort=0: cm_ptr <= wr_ptr+1 and pkt_count+1. The frame is readable from the next cycle.
  - wr_abort=1: wr_ptr <= cm_ptr, drop_cnt+1. The beat is not stored.
- Overflow: wr_en=1 with full=1 in normal state enters DROP state and rewinds wr_ptr <= cm_ptr. The offending beat is discarded.
- DROP state: every wr_en beat is accepted and discarded regardless of full. On a wr_last beat: drop_cnt+1, return to normal. If the overflowing beat itself has wr_last=1: drop_cnt+1 immediately and stay in normal state.
- Frames longer than DEPTH always overflow and are dropped.
- Read: rd_en=1 and empty=0 -> next cycle rd_valid=1, rd_data/rd_last from entry rd_ptr; rd_ptr+1. Latency is 1 cycle.
- rd_en with empty=1 is ignored: rd_valid=0 next cycle, rd_data/rd_last hold their previous values.
- Read of a beat with last=1 decrements pkt_count.
- Same cycle commit and last-beat read: pkt_count unchanged. Same cycle write and read: level unchanged.
- Reading frees space the same cycle it is registered, so full deasserts the cycle after the read.
- Abort/overflow rewind never disturbs rd_ptr or cm_ptr. Committed data is immutable.

Decomposition:
- eth_pkg gains: pkt_fifo state enum (NORMAL, DROP), and a function returning ptr width for a given DEPTH.
- Sub-module sdp_ram (WIDTH+1 x DEPTH, one write port, registered read port) holds storage. The FIFO keeps pointers, FSM, flags and counters.

Test Plan:
1. Reset, write 3-beat frame 0x11,0x22,0x33(last) with DEPTH=8 -> empty=0 cycle after last beat, pkt_count=1. Read 3 -> rd_data 0x11,0x22,0x33, rd_last on 3rd, empty=1, pkt_count=0.
2. Write 4 beats with wr_abort on last -> level returns to 0, empty stays 1 throughout, drop_cnt=1.
3. DEPTH=8, no reads, write 10-beat frame -> full after 8 beats; beat 9 triggers DROP, level=0; beat 10 (last) -> drop_cnt=1. A following 2-beat frame is committed and read back correctly.
4. Committed frame A (5 beats) pending, then frame B overflows -> A reads back intact, B never visible, pkt_count 1->0.
5. Stream frames while reading continuously across pointer wrap (40 frames of 3 beats, DEPTH=8) -> all data in order, no drops, afull tracks level >= DEPTH-AFULL_MARGIN.
6. Assert rstn=0 mid-frame and mid-read -> all outputs at reset values immediately; post-reset frame works normally.
